udp_tx_pattern_gen: RTL and testbench

- Parametrised UDP transmit stimulus source.
- On a start command it issues one UDP TX header, then a payload of `length` bytes filled from a selectable test pattern.
- The payload is `DATA_W` bits wide per beat and uses a valid/ready/last/keep handshake, adding backpressure and multi-byte beats that the byte-wide `axi_out_type` stream lacks.
- It sits in front of the UDP TX path as a traffic generator for bring-up and loopback tests.

---
 rtl/udp_tx_pattern_gen_if.sv | 54 +++++
 rtl/udp_tx_pattern_gen.sv | 164 ++++++++++++++++
 tb/tb_udp_tx_pattern_gen.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_pattern_gen_if.sv
// rtl/udp_tx_pattern_gen_if.sv - command, header and payload signals of the UDP TX pattern generator
interface udp_tx_pattern_gen_if #(
   parameter int DATA_W = 8
);
   localparam int BPB = DATA_W / 8;

   // command side
   logic              start;
   logic [3:0]        pattern;
   logic [15:0]       length;
   logic [31:0]       dst_ip;
   logic [15:0]       dst_port;
   logic [15:0]       src_port;

   // header handshake
   logic              hdr_valid;
   logic              hdr_ready;
   logic [31:0]       hdr_dst_ip;
   logic [15:0]       hdr_dst_port;
   logic [15:0]       hdr_src_port;
   logic [15:0]       hdr_data_length;
   logic [15:0]       hdr_checksum;

   // payload stream
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] tx_data;
   logic [BPB-1:0]    tx_keep;
   logic              tx_last;

   // status
   logic              busy;
   logic              err;
   logic              done;
   logic [15:0]       frame_cnt;

   // generator side: sources header and payload
   modport master (
      input  start, pattern, length, dst_ip, dst_port, src_port,
      input  hdr_ready, tx_ready,
      output hdr_valid, hdr_dst_ip, hdr_dst_port, hdr_src_port, hdr_data_length, hdr_checksum,
      output tx_valid, tx_data, tx_keep, tx_last,
      output busy, err, done, frame_cnt
   );

   // controlling / consuming side
   modport slave (
      output start, pattern, length, dst_ip, dst_port, src_port,
      output hdr_ready, tx_ready,
      input  hdr_valid, hdr_dst_ip, hdr_dst_port, hdr_src_port, hdr_data_length, hdr_checksum,
      input  tx_valid, tx_data, tx_keep, tx_last,
      input  busy, err, done, frame_cnt
   );
endinterface

// File: rtl/udp_tx_pattern_gen.sv
// rtl/udp_tx_pattern_gen.sv - UDP TX header plus test-pattern payload generator
module udp_tx_pattern_gen #(
   parameter int         DATA_W    = 8,
   parameter int         MAX_LEN   = 1472,
   parameter logic [7:0] LFSR_SEED = 8'hFF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   udp_tx_pattern_gen_if.master bus
);
   localparam int BPB = DATA_W / 8;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

   state_t      state_q, state_d;
   logic [3:0]  pattern_q, pattern_d;
   logic [15:0] len_q, len_d;
   logic [31:0] ip_q, ip_d;
   logic [15:0] dport_q, dport_d;
   logic [15:0] sport_q, sport_d;
   logic [15:0] idx_q, idx_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic        err_q, err_d;
   logic        done_q, done_d;
   logic [15:0] frame_q, frame_d;

   logic [DATA_W-1:0] beat_data;
   logic [BPB-1:0]    beat_keep;
   logic              beat_last;
   logic [7:0]        lfsr_end;
   logic [7:0]        lfsr_walk;
   logic [15:0]       byte_idx;
   logic              bad_req;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   function automatic logic [7:0] pat_byte(input logic [3:0] p, input logic [15:0] i,
                                           input logic [7:0] s);
      case (p)
         4'd0:    return 8'h00;
         4'd1:    return 8'hFF;
         4'd2:    return {8{i[0]}};
         4'd3:    return {8{i[3]}};
         4'd4:    return i[7:0];
         4'd5:    return i[8] ? (8'hFF - i[7:0]) : i[7:0];
         4'd6:    return s;
         default: return 8'h00;
      endcase
   endfunction

   // Build the current beat; the LFSR is walked only across bytes that lie inside the frame
   always_comb begin
      beat_data = '0;
      beat_keep = '0;
      byte_idx  = '0;
      lfsr_walk = lfsr_q;
      for (int k = 0; k < BPB; k++) begin
         byte_idx = idx_q + 16'(k);
         if (byte_idx < len_q) begin
            beat_keep[k]        = 1'b1;
            beat_data[8*k +: 8] = pat_byte(pattern_q, byte_idx, lfsr_walk);
            lfsr_walk           = lfsr_next(lfsr_walk);
         end
      end
      lfsr_end  = lfsr_walk;
      beat_last = ({1'b0, idx_q} + 17'(BPB)) >= {1'b0, len_q};
   end

   assign bad_req = (bus.length == 16'd0) || (int'(bus.length) > MAX_LEN) || (bus.pattern > 4'd6);

   // Next-state: command acceptance, header handshake, beat advance and frame completion
   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      len_d     = len_q;
      ip_d      = ip_q;
      dport_d   = dport_q;
      sport_d   = sport_q;
      idx_d     = idx_q;
      lfsr_d    = lfsr_q;
      frame_d   = frame_q;
      err_d     = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bad_req) begin
                  err_d = 1'b1;
               end else begin
                  pattern_d = bus.pattern;
                  len_d     = bus.length;
                  ip_d      = bus.dst_ip;
                  dport_d   = bus.dst_port;
                  sport_d   = bus.src_port;
                  idx_d     = '0;
                  lfsr_d    = LFSR_SEED;
                  state_d   = S_HDR;
               end
            end
         end
         S_HDR: begin
            if (bus.hdr_ready) state_d = S_DATA;
         end
         S_DATA: begin
            if (bus.tx_ready) begin
               idx_d  = idx_q + 16'(BPB);
               lfsr_d = lfsr_end;
               if (beat_last) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  frame_d = frame_q + 16'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any frame in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pattern_q <= '0;
         len_q     <= '0;
         ip_q      <= '0;
         dport_q   <= '0;
         sport_q   <= '0;
         idx_q     <= '0;
         lfsr_q    <= LFSR_SEED;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         frame_q   <= '0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         len_q     <= len_d;
         ip_q      <= ip_d;
         dport_q   <= dport_d;
         sport_q   <= sport_d;
         idx_q     <= idx_d;
         lfsr_q    <= lfsr_d;
         err_q     <= err_d;
         done_q    <= done_d;
         frame_q   <= frame_d;
      end
   end

   assign bus.hdr_valid       = (state_q == S_HDR);
   assign bus.hdr_dst_ip      = ip_q;
   assign bus.hdr_dst_port    = dport_q;
   assign bus.hdr_src_port    = sport_q;
   assign bus.hdr_data_length = len_q;
   assign bus.hdr_checksum    = '0;
   assign bus.tx_valid        = (state_q == S_DATA);
   assign bus.tx_data         = bus.tx_valid ? beat_data : '0;
   assign bus.tx_keep         = bus.tx_valid ? beat_keep : '0;
   assign bus.tx_last         = bus.tx_valid & beat_last;
   assign bus.busy            = (state_q != S_IDLE);
   assign bus.err             = err_q;
   assign bus.done            = done_q;
   assign bus.frame_cnt       = frame_q;
endmodule

// File: tb/tb_udp_tx_pattern_gen.sv
// tb/tb_udp_tx_pattern_gen.sv - scoreboard bench for udp_tx_pattern_gen
module tb_udp_tx_pattern_gen;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   udp_tx_pattern_gen_if #(.DATA_W(8))  b8 ();
   udp_tx_pattern_gen_if #(.DATA_W(32)) b32 ();

   udp_tx_pattern_gen #(.DATA_W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.master));
   udp_tx_pattern_gen #(.DATA_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.master));

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   typedef struct packed {
      logic [15:0] len;
      logic [31:0] ip;
      logic [15:0] dp;
      logic [15:0] sp;
   } hdr_t;

   beat_t q8[$];
   beat_t q32[$];
   hdr_t  h8[$];
   hdr_t  h32[$];
   logic [7:0] rx8[$];

   int acc8 = 0, done8 = 0, err8 = 0, done32 = 0;
   bit rand_ready = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s actual=event expected=none", name);
   endtask

   task automatic push8(input logic [7:0] d, input logic l);
      beat_t b;
      b.data = 64'(d);
      b.keep = 8'h1;
      b.last = l;
      q8.push_back(b);
   endtask

   task automatic push8_model(input int p, input int len);
      int v;
      for (int i = 0; i < len; i++) begin
         case (p)
            1: v = 255;
            4: v = i % 256;
            5: v = (i < 256) ? i : ((i < 512) ? 511 - i : i - 512);
            default: v = 0;
         endcase
         push8(8'(v), i == len - 1);
      end
   endtask

   task automatic push_hdr8(input logic [15:0] len, input logic [31:0] ip,
                            input logic [15:0] dp, input logic [15:0] sp);
      hdr_t h;
      h.len = len; h.ip = ip; h.dp = dp; h.sp = sp;
      h8.push_back(h);
   endtask

   // DUT8 monitor: scoreboard pop, hold-while-stalled check, pulse counting
   logic       prev_stall8 = 1'b0;
   logic [7:0] prev_d8;
   logic       prev_k8, prev_l8;
   beat_t      e8;
   hdr_t       eh8;
   always @(negedge clk) begin
      if (rst_n) begin
         if (b8.tx_valid && prev_stall8) begin
            chk("stall_data", 64'(b8.tx_data), 64'(prev_d8));
            chk("stall_keep", 64'(b8.tx_keep), 64'(prev_k8));
            chk("stall_last", 64'(b8.tx_last), 64'(prev_l8));
         end
         if (b8.tx_valid && b8.tx_ready) begin
            if (q8.size() == 0) fail("unexpected_beat8");
            else begin
               e8 = q8.pop_front();
               chk("beat8_data", 64'(b8.tx_data), e8.data);
               chk("beat8_keep", 64'(b8.tx_keep), 64'(e8.keep));
               chk("beat8_last", 64'(b8.tx_last), 64'(e8.last));
            end
            rx8.push_back(b8.tx_data);
            acc8++;
         end
         if (b8.hdr_valid && b8.hdr_ready) begin
            if (h8.size() == 0) fail("unexpected_hdr8");
            else begin
               eh8 = h8.pop_front();
               chk("hdr8_len", 64'(b8.hdr_data_length), 64'(eh8.len));
               chk("hdr8_ip", 64'(b8.hdr_dst_ip), 64'(eh8.ip));
               chk("hdr8_dport", 64'(b8.hdr_dst_port), 64'(eh8.dp));
               chk("hdr8_sport", 64'(b8.hdr_src_port), 64'(eh8.sp));
               chk("hdr8_csum", 64'(b8.hdr_checksum), 64'h0);
            end
         end
         if (b8.done) done8++;
         if (b8.err) err8++;
         prev_stall8 = b8.tx_valid && !b8.tx_ready;
         prev_d8     = b8.tx_data;
         prev_k8     = b8.tx_keep;
         prev_l8     = b8.tx_last;
      end else begin
         prev_stall8 = 1'b0;
      end
   end

   // DUT32 monitor: scoreboard pop for the wide-beat instance
   beat_t e32;
   hdr_t  eh32;
   always @(negedge clk) begin
      if (rst_n) begin
         if (b32.tx_valid && b32.tx_ready) begin
            if (q32.size() == 0) fail("unexpected_beat32");
            else begin
               e32 = q32.pop_front();
               chk("beat32_data", 64'(b32.tx_data), e32.data);
               chk("beat32_keep", 64'(b32.tx_keep), 64'(e32.keep));
               chk("beat32_last", 64'(b32.tx_last), 64'(e32.last));
            end
         end
         if (b32.hdr_valid && b32.hdr_ready) begin
            if (h32.size() == 0) fail("unexpected_hdr32");
            else begin
               eh32 = h32.pop_front();
               chk("hdr32_len", 64'(b32.hdr_data_length), 64'(eh32.len));
               chk("hdr32_ip", 64'(b32.hdr_dst_ip), 64'(eh32.ip));
            end
         end
         if (b32.done) done32++;
      end
   end

   // tx_ready driver for DUT8: constant high or random stalls
   initial begin
      forever begin
         @(posedge clk);
         #1;
         b8.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic start8(input logic [3:0] p, input logic [15:0] len, input logic [31:0] ip,
                         input logic [15:0] dp, input logic [15:0] sp);
      @(posedge clk);
      #1;
      b8.pattern = p; b8.length = len; b8.dst_ip = ip; b8.dst_port = dp; b8.src_port = sp;
      b8.start = 1'b1;
      @(posedge clk);
      #1;
      b8.start = 1'b0;
   endtask

   task automatic wait_done8(input int base, input string name);
      int n = 0;
      while (done8 == base && n < 5000) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (done8 == base) fail({name, "_timeout"});
      chk({name, "_queue_empty"}, 64'(q8.size()), 64'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   int base, eb, n;
   logic [15:0] exp_frames;

   initial begin
      b8.start = 0; b8.pattern = 0; b8.length = 0; b8.dst_ip = 0; b8.dst_port = 0; b8.src_port = 0;
      b8.hdr_ready = 1; b8.tx_ready = 1;
      b32.start = 0; b32.pattern = 0; b32.length = 0; b32.dst_ip = 0; b32.dst_port = 0;
      b32.src_port = 0; b32.hdr_ready = 1; b32.tx_ready = 1;
      exp_frames = 0;

      repeat (3) @(posedge clk);
      #2;
      chk("rst_busy", 64'(b8.busy), 64'h0);
      chk("rst_hdr_valid", 64'(b8.hdr_valid), 64'h0);
      chk("rst_tx_valid", 64'(b8.tx_valid), 64'h0);
      chk("rst_frame_cnt", 64'(b8.frame_cnt), 64'h0);
      chk("rst_err", 64'(b8.err), 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // RAMP, length 4, byte-wide
      push_hdr8(16'd4, 32'hC0A8_0001, 16'd5000, 16'd6000);
      push8(8'h00, 0); push8(8'h01, 0); push8(8'h02, 0); push8(8'h03, 1);
      base = done8;
      start8(4'd4, 16'd4, 32'hC0A8_0001, 16'd5000, 16'd6000);
      wait_done8(base, "ramp4");
      exp_frames++;
      chk("ramp4_frame_cnt", 64'(b8.frame_cnt), 64'(exp_frames));

      // ZEROS_ONES, length 6, 32-bit beats
      begin
         hdr_t h;
         beat_t b;
         h.len = 16'd6; h.ip = 32'h0A00_0002; h.dp = 16'd1; h.sp = 16'd2;
         h32.push_back(h);
         b.data = 64'hFF00_FF00; b.keep = 8'hF; b.last = 1'b0; q32.push_back(b);
         b.data = 64'h0000_FF00; b.keep = 8'h3; b.last = 1'b1; q32.push_back(b);
      end
      base = done32;
      @(posedge clk);
      #1;
      b32.pattern = 4'd2; b32.length = 16'd6; b32.dst_ip = 32'h0A00_0002;
      b32.dst_port = 16'd1; b32.src_port = 16'd2; b32.start = 1'b1;
      @(posedge clk);
      #1;
      b32.start = 1'b0;
      n = 0;
      while (done32 == base && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (done32 == base) fail("zo32_timeout");
      chk("zo32_queue_empty", 64'(q32.size()), 64'h0);
      chk("zo32_frame_cnt", 64'(b32.frame_cnt), 64'h1);

      // PRBS twice: seed reload gives the same bytes
      for (int r = 0; r < 2; r++) begin
         push_hdr8(16'd3, 32'h1, 16'd3, 16'd4);
         push8(8'hFF, 0); push8(8'hFE, 0); push8(8'hFC, 1);
         base = done8;
         start8(4'd6, 16'd3, 32'h1, 16'd3, 16'd4);
         wait_done8(base, "prbs3");
         exp_frames++;
         chk("prbs3_frame_cnt", 64'(b8.frame_cnt), 64'(exp_frames));
      end

      // TRIANGLE, length 600, random stalls
      rx8.delete();
      push_hdr8(16'd600, 32'h2, 16'd7, 16'd8);
      push8_model(5, 600);
      rand_ready = 1'b1;
      base = done8;
      start8(4'd5, 16'd600, 32'h2, 16'd7, 16'd8);
      wait_done8(base, "tri600");
      rand_ready = 1'b0;
      exp_frames++;
      chk("tri600_count", 64'(rx8.size()), 64'd600);
      if (rx8.size() == 600) begin
         chk("tri_b255", 64'(rx8[255]), 64'hFF);
         chk("tri_b256", 64'(rx8[256]), 64'hFF);
         chk("tri_b257", 64'(rx8[257]), 64'hFE);
         chk("tri_b511", 64'(rx8[511]), 64'h00);
      end
      chk("tri600_frame_cnt", 64'(b8.frame_cnt), 64'(exp_frames));

      // Rejected requests: zero length, over-length, bad pattern
      for (int v = 0; v < 3; v++) begin
         eb = err8;
         case (v)
            0: start8(4'd4, 16'd0, 32'h3, 16'd1, 16'd1);
            1: start8(4'd4, 16'd1473, 32'h3, 16'd1, 16'd1);
            default: start8(4'd7, 16'd10, 32'h3, 16'd1, 16'd1);
         endcase
         repeat (3) @(posedge clk);
         #2;
         chk("reject_err_pulses", 64'(err8 - eb), 64'h1);
         chk("reject_busy", 64'(b8.busy), 64'h0);
         chk("reject_hdr_valid", 64'(b8.hdr_valid), 64'h0);
      end

      // Start held during a frame is ignored
      push_hdr8(16'd20, 32'h4, 16'd9, 16'd10);
      push8_model(1, 20);
      eb = err8;
      base = done8;
      start8(4'd1, 16'd20, 32'h4, 16'd9, 16'd10);
      b8.pattern = 4'd4; b8.length = 16'd4; b8.start = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      b8.start = 1'b0;
      wait_done8(base, "held_start");
      exp_frames++;
      repeat (3) @(posedge clk);
      #2;
      chk("held_start_err", 64'(err8 - eb), 64'h0);
      chk("held_start_idle", 64'(b8.busy), 64'h0);
      chk("held_start_frame_cnt", 64'(b8.frame_cnt), 64'(exp_frames));

      // Reset mid-frame, then a clean frame
      push_hdr8(16'd10, 32'h5, 16'd11, 16'd12);
      push8_model(4, 10);
      base = acc8;
      eb = done8;
      start8(4'd4, 16'd10, 32'h5, 16'd11, 16'd12);
      n = 0;
      while (acc8 < base + 2 && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (acc8 < base + 2) fail("mid_reset_timeout");
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx_valid", 64'(b8.tx_valid), 64'h0);
      chk("mid_rst_tx_data", 64'(b8.tx_data), 64'h0);
      chk("mid_rst_tx_last", 64'(b8.tx_last), 64'h0);
      chk("mid_rst_busy", 64'(b8.busy), 64'h0);
      chk("mid_rst_frame_cnt", 64'(b8.frame_cnt), 64'h0);
      chk("mid_rst_done", 64'(b8.done), 64'h0);
      q8.delete();
      h8.delete();
      exp_frames = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mid_rst_no_done", 64'(done8 - eb), 64'h0);
      push_hdr8(16'd10, 32'h6, 16'd13, 16'd14);
      push8_model(4, 10);
      base = done8;
      start8(4'd4, 16'd10, 32'h6, 16'd13, 16'd14);
      wait_done8(base, "post_rst");
      exp_frames++;
      chk("post_rst_frame_cnt", 64'(b8.frame_cnt), 64'(exp_frames));

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
